// File: rtl/spi_dac_rx.sv
// spi_dac_rx: dual-lane SPI receiver acting as a DAC model.
// Oversamples CS/SCK/MOSI in the clk domain, shifts both lanes on the
// synced SCK falling edge and publishes 12-bit code + 2-bit power-down
// mode per channel when a frame of exactly FRAME_BITS bits closes.
// Optional build macro: SPI_DAC_RX_FRAME_CNT_EN (valid-frame counter).
module spi_dac_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        spi_cs_ni,
    input  logic        spi_sck_i,
    input  logic [1:0]  spi_mosi_i,
    output logic [11:0] data0_o,
    output logic [1:0]  data_pd0_o,
    output logic [11:0] data1_o,
    output logic [1:0]  data_pd1_o,
    output logic        data_valid_o,
    output logic        frame_err_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [4:0] LP_FRAME_BITS = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi0_sync;
    logic [SYNC_STAGES-1:0] r_mosi1_sync;
    logic                   r_cs_d;
    logic                   r_sck_d;

    logic w_cs;
    logic w_sck;
    logic w_mosi0;
    logic w_mosi1;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    logic w_start;
    logic w_shift;
    logic w_load;
    logic w_err;

    // Only bits [13:0] of each lane word are ever used; bits [15:14]
    // simply fall off the top of a 14-bit shift register.
    logic [13:0] r_sreg0;
    logic [13:0] r_sreg1;
    logic [4:0]  r_bit_cnt;

    logic [11:0] r_data0;
    logic [1:0]  r_pd0;
    logic [11:0] r_data1;
    logic [1:0]  r_pd1;
    logic        r_valid;
    logic        r_err;
    logic        r_busy;

    // Synchronizer chains plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cs_sync    <= '1;
            r_sck_sync   <= '0;
            r_mosi0_sync <= '0;
            r_mosi1_sync <= '0;
            r_cs_d       <= 1'b1;
            r_sck_d      <= 1'b0;
        end else begin
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            r_sck_sync   <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_mosi0_sync <= {r_mosi0_sync[SYNC_STAGES-2:0], spi_mosi_i[0]};
            r_mosi1_sync <= {r_mosi1_sync[SYNC_STAGES-2:0], spi_mosi_i[1]};
            r_cs_d       <= r_cs_sync[SYNC_STAGES-1];
            r_sck_d      <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi0    = r_mosi0_sync[SYNC_STAGES-1];
    assign w_mosi1    = r_mosi1_sync[SYNC_STAGES-1];
    assign w_sck_fall = r_sck_d & ~w_sck;
    assign w_cs_fall  = r_cs_d & ~w_cs;
    assign w_cs_rise  = ~r_cs_d & w_cs;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && en_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = w_sck_fall;
                if (w_cs_rise) begin
                    w_state_nxt = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (r_bit_cnt == LP_FRAME_BITS) begin
                    w_load = 1'b1;
                end else begin
                    w_err  = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter, output registers and pulses.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sreg0   <= '0;
            r_sreg1   <= '0;
            r_bit_cnt <= '0;
            r_data0   <= '0;
            r_pd0     <= '0;
            r_data1   <= '0;
            r_pd1     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= w_load;
            r_err   <= w_err;
            if (w_start) begin
                r_sreg0   <= '0;
                r_sreg1   <= '0;
                r_bit_cnt <= '0;
                r_busy    <= 1'b1;
            end
            if (w_shift) begin
                r_sreg0 <= {r_sreg0[12:0], w_mosi0};
                r_sreg1 <= {r_sreg1[12:0], w_mosi1};
                if (r_bit_cnt != '1) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            if (w_load) begin
                r_data0 <= r_sreg0[11:0];
                r_pd0   <= r_sreg0[13:12];
                r_data1 <= r_sreg1[11:0];
                r_pd1   <= r_sreg1[13:12];
            end
            if (r_state == ST_CLOSE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign data0_o      = r_data0;
    assign data_pd0_o   = r_pd0;
    assign data1_o      = r_data1;
    assign data_pd1_o   = r_pd1;
    assign data_valid_o = r_valid;
    assign frame_err_o  = r_err;
    assign busy_o       = r_busy;

`ifdef SPI_DAC_RX_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Valid-frame counter, advances with each load; wraps naturally.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_cnt <= '0;
        end else if (w_load) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt_o = r_frame_cnt;
`else
    assign frame_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: directed self-checking bench for spi_dac_rx.
module tb_spi_dac_rx;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst_ni;
    logic        en_i;
    logic        spi_cs_ni;
    logic        spi_sck_i;
    logic [1:0]  spi_mosi_i;
    logic [11:0] data0_o;
    logic [1:0]  data_pd0_o;
    logic [11:0] data1_o;
    logic [1:0]  data_pd1_o;
    logic        data_valid_o;
    logic        frame_err_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    spi_dac_rx #(
        .SYNC_STAGES (SYNC),
        .FRAME_BITS  (16)
    ) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .spi_cs_ni    (spi_cs_ni),
        .spi_sck_i    (spi_sck_i),
        .spi_mosi_i   (spi_mosi_i),
        .data0_o      (data0_o),
        .data_pd0_o   (data_pd0_o),
        .data1_o      (data1_o),
        .data_pd1_o   (data_pd1_o),
        .data_valid_o (data_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int cyc      = 0;
    int valid_cyc = 0;
    int cs_cyc   = 0;
    int half     = 15;
    int exp_cnt  = 0;
    bit busy_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse/level monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (data_valid_o) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (frame_err_o) n_err = n_err + 1;
        if (busy_o) busy_seen = 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Sends nbits bits MSB first (bits past 16 are zero padding).
    // simul=1 raises CS in the same instant as the last SCK fall.
    task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input int nbits, input bit simul);
        wait_clk(2);
        spi_cs_ni = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nbits; i++) begin
            spi_sck_i  = 1'b1;
            spi_mosi_i = (i < 16) ? {w1[15-i], w0[15-i]} : 2'b00;
            wait_clk(half);
            if (simul && i == nbits - 1) begin
                spi_sck_i = 1'b0;
                spi_cs_ni = 1'b1;
                cs_cyc    = cyc;
            end else begin
                spi_sck_i = 1'b0;
                wait_clk(half);
            end
        end
        if (!simul) begin
            spi_cs_ni = 1'b1;
            cs_cyc    = cyc;
        end
        wait_clk(SYNC + 6);
    endtask

    task automatic check_out(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                             input int dv, input int de, input int v0, input int e0);
        check_eq({tag, ".data0"}, 32'(data0_o), 32'(w0[11:0]));
        check_eq({tag, ".pd0"},   32'(data_pd0_o), 32'(w0[13:12]));
        check_eq({tag, ".data1"}, 32'(data1_o), 32'(w1[11:0]));
        check_eq({tag, ".pd1"},   32'(data_pd1_o), 32'(w1[13:12]));
        check_eq({tag, ".nvalid"}, 32'(n_valid - v0), 32'(dv));
        check_eq({tag, ".nerr"},   32'(n_err - e0), 32'(de));
    endtask

    initial begin
        int v0, e0;
        logic [15:0] r0, r1;
        rst_ni     = 1'b0;
        en_i       = 1'b1;
        spi_cs_ni  = 1'b1;
        spi_sck_i  = 1'b0;
        spi_mosi_i = 2'b00;
        wait_clk(3);
        check_eq("rst.data0", 32'(data0_o), 32'h0);
        check_eq("rst.data1", 32'(data1_o), 32'h0);
        check_eq("rst.pd", 32'({data_pd0_o, data_pd1_o}), 32'h0);
        check_eq("rst.flags", 32'({data_valid_o, frame_err_o, busy_o}), 32'h0);
        check_eq("rst.cnt", 32'(frame_cnt_o), 32'h0);
        rst_ni = 1'b1;
        wait_clk(3);

        // Single frame, half period 15.
        v0 = n_valid; e0 = n_err; busy_seen = 0;
        send_frame(16'h1ABC, 16'h2123, 16, 0);
        exp_cnt++;
        check_out("single", 16'h1ABC, 16'h2123, 1, 0, v0, e0);
        check_eq("single.busy_seen", 32'(busy_seen), 32'h1);
        check_eq("single.busy_end", 32'(busy_o), 32'h0);
        check_eq("single.latency", 32'(valid_cyc - cs_cyc), 32'(SYNC + 2));

        // Short and long frames: error pulse, outputs unchanged.
        half = 6;
        v0 = n_valid; e0 = n_err;
        send_frame(16'h3555, 16'h0777, 12, 0);
        check_out("short12", 16'h1ABC, 16'h2123, 0, 1, v0, e0);
        v0 = n_valid; e0 = n_err;
        send_frame(16'h3555, 16'h0777, 20, 0);
        check_out("long20", 16'h1ABC, 16'h2123, 0, 1, v0, e0);

        // Disabled at CS fall, enabled mid-frame: frame skipped.
        v0 = n_valid; e0 = n_err; busy_seen = 0;
        en_i = 1'b0;
        fork
            send_frame(16'h0123, 16'h0456, 16, 0);
            begin wait_clk(60); en_i = 1'b1; end
        join
        check_out("skip", 16'h1ABC, 16'h2123, 0, 0, v0, e0);
        check_eq("skip.busy_seen", 32'(busy_seen), 32'h0);
        v0 = n_valid; e0 = n_err;
        send_frame(16'h3FFF, 16'h0000, 16, 0);
        exp_cnt++;
        check_out("after_skip", 16'h3FFF, 16'h0000, 1, 0, v0, e0);

        // Last SCK fall coincident with CS rise.
        v0 = n_valid; e0 = n_err;
        send_frame(16'h2DEF, 16'h1234, 16, 1);
        exp_cnt++;
        check_out("simul", 16'h2DEF, 16'h1234, 1, 0, v0, e0);

        // Asynchronous reset mid-frame.
        wait_clk(2);
        spi_cs_ni = 1'b0;
        wait_clk(half);
        for (int i = 0; i < 8; i++) begin
            spi_sck_i = 1'b1; spi_mosi_i = 2'b11; wait_clk(half);
            spi_sck_i = 1'b0; wait_clk(half);
        end
        rst_ni = 1'b0;
        #1;
        check_eq("midrst.data0", 32'(data0_o), 32'h0);
        check_eq("midrst.pd0", 32'(data_pd0_o), 32'h0);
        check_eq("midrst.data1", 32'(data1_o), 32'h0);
        check_eq("midrst.busy", 32'(busy_o), 32'h0);
        check_eq("midrst.cnt", 32'(frame_cnt_o), 32'h0);
        exp_cnt = 0;
        spi_cs_ni = 1'b1;
        wait_clk(3);
        rst_ni = 1'b1;
        wait_clk(3);
        v0 = n_valid; e0 = n_err;
        send_frame(16'h0555, 16'h0AAA, 16, 0);
        exp_cnt++;
        check_out("postrst", 16'h0555, 16'h0AAA, 1, 0, v0, e0);

        // Random frames at the minimum legal SCK phase length.
        half = SYNC + 2;
        for (int k = 0; k < 100; k++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            v0 = n_valid; e0 = n_err;
            send_frame(r0, r1, 16, 0);
            exp_cnt++;
            check_out("rand", r0, r1, 1, 0, v0, e0);
        end

`ifdef SPI_DAC_RX_FRAME_CNT_EN
        check_eq("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        force dut.r_frame_cnt = 16'hFFFE;
        wait_clk(1);
        release dut.r_frame_cnt;
        send_frame(16'h0001, 16'h0002, 16, 0);
        check_eq("cnt_ffff", 32'(frame_cnt_o), 32'hFFFF);
        send_frame(16'h0003, 16'h0004, 16, 0);
        check_eq("cnt_wrap", 32'(frame_cnt_o), 32'h0000);
`else
        check_eq("frame_cnt_tied", 32'(frame_cnt_o), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_dac_rx.md
Name: spi_dac_rx

Overview:
- SPI receiver/responder for the dual-lane DAC frame stream: lane 0 on spi_mosi_i[0], lane 1 on spi_mosi_i[1], one shared SCK and active-low CS.
- Oversamples the SPI pins in the system clock domain, deserialises both lanes in parallel and presents each completed frame as 12-bit code plus 2-bit power-down mode per channel.
- Used as the loopback/DAC model in the measurement example so the DAC driver output can be checked in simulation and on hardware.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on spi_cs_ni, spi_sck_i and spi_mosi_i; legal range 2..4.
- FRAME_BITS, 16, SCK falling edges per valid frame; fixed to 16 in this revision.

Ports:
- clk  input  1  system clock.
- rst_ni  input  1  asynchronous reset, active low.
- en_i  input  1  receive enable.
- spi_cs_ni  input  1  SPI chip select, active low, asynchronous to clk.
- spi_sck_i  input  1  SPI clock, asynchronous to clk.
- spi_mosi_i  input  2  serial data; [0] = channel 0, [1] = channel 1.
- data0_o  output  12  last valid channel 0 code.
- data_pd0_o  output  2  last valid channel 0 power-down mode.
- data1_o  output  12  last valid channel 1 code.
- data_pd1_o  output  2  last valid channel 1 power-down mode.
- data_valid_o  output  1  one-clk pulse; new frame on the data outputs.
- frame_err_o  output  1  one-clk pulse; frame closed with bit count != 16.
- busy_o  output  1  high while a frame is being received.
- frame_cnt_o  output  16  valid-frame counter (see Optional Feature).

Behaviour:
- Reset values:
  - All data outputs 0.
  - data_valid_o, frame_err_o and busy_o are 0.
  - frame_cnt_o is 0.
  - Synchronizers preset: CS = 1, SCK = 0, MOSI = 0.
- Input conditioning and edge detection:
  - All SPI inputs pass through SYNC_STAGES flops.
  - Edges are detected from the last synced stage against one extra delay flop.
  - sck_fall = prev 1 and now 0. cs_fall and cs_rise are derived the same way.
  - Requirement on the driver: SCK high and low phases are each >= SYNC_STAGES+2 clk cycles.
- Frame format:
  - MSB first, 16 bits per lane.
  - Bits [15:14] are don't-care. Bits [13:12] are the pd value. Bits [11:0] are the code.
  - Data is sampled on the synced SCK falling edge, using the synced MOSI value from the same cycle.
- FSM states: IDLE, SHIFT, CLOSE.
  - IDLE: on cs_fall with en_i = 1, clear bit_cnt and both shift registers, set busy_o, go to SHIFT. A cs_fall with en_i = 0 is ignored; the frame is skipped until the next cs_fall.
  - SHIFT: on each sck_fall, shift {sreg, mosi[n]} into each 16-bit shift register and increment bit_cnt. bit_cnt is 5 bits and saturates at 31. On cs_rise go to CLOSE.
  - SHIFT, simultaneous sck_fall and cs_rise: the sample is taken first, then the FSM goes to CLOSE.
  - CLOSE (one cycle), bit_cnt == 16: load data0_o = sreg0[11:0], data_pd0_o = sreg0[13:12], and likewise for channel 1. Pulse data_valid_o in the same cycle as the load.
  - CLOSE, bit_cnt != 16: pulse frame_err_o; outputs keep their old values.
  - CLOSE exit: clear busy_o, return to IDLE.
- Output latency: data_valid_o rises SYNC_STAGES+2 clk cycles after the raw CS rising edge.
- SCK edges seen while CS is high are ignored.
- en_i deasserted mid-frame: the current frame completes normally; no new frame is started.
- A cs_fall in CLOSE cannot occur under the SCK timing rule. If it does, it is ignored.
- Asynchronous reset mid-frame returns everything to reset values immediately. The partial frame is lost; the next full frame after reset release is received normally.
- Outputs are registered; there are no combinational paths from pins to outputs.

Optional Feature:
- Macro: SPI_DAC_RX_FRAME_CNT_EN.
- Defined: frame_cnt_o increments by 1 in the same cycle as each data_valid_o pulse and wraps 16'hFFFF -> 16'h0000. Error frames do not count. Reset value is 0.
- Not defined: the counter logic is absent and frame_cnt_o is tied to 16'h0000. The port list is identical in both builds.

Test Plan:
- Single frame, lane 0 word 16'h1ABC, lane 1 word 16'h2123, en_i = 1, SCK half period 15 clk -> one data_valid_o pulse with data0_o = 12'hABC, data_pd0_o = 2'b01, data1_o = 12'h123, data_pd1_o = 2'b10. frame_err_o stays 0.
- Short frame, CS released after 12 SCK falls -> frame_err_o pulses once, no data_valid_o, outputs unchanged from the previous frame. Repeat with 20 SCK falls: same result.
- en_i = 0 at CS fall, then en_i = 1 mid-frame -> no busy_o, no data_valid_o for that frame. Next frame 16'h3FFF / 16'h0000 is received: data0_o = 12'hFFF, data_pd0_o = 2'b11, data1_o = 12'h000, data_pd1_o = 2'b00.
- rst_ni pulsed low after 8 SCK falls -> all outputs 0 immediately. The next complete frame 16'h0555 / 16'h0AAA gives data0_o = 12'h555, data1_o = 12'hAAA.
- Loopback with the DAC driver running continuously, 1000 frames of random codes -> every frame matches the sent codes, no frame_err_o. With SPI_DAC_RX_FRAME_CNT_EN defined, frame_cnt_o = 1000; preloaded to 16'hFFFE (via force), it wraps to 16'h0000 after 2 frames.
- Last SCK fall and CS rise in the same synced cycle -> bit 16 is captured and data_valid_o is asserted with the correct word.
